// File: rtl/otter_cu_fsm_pkg.sv
// Shared types for the Otter multicycle control unit: RV32I major opcodes,
// controller states and the funct3 that marks MRET within SYSTEM.
package otter_pkg;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        INIT,
        FETCH,
        EXEC,
        WB,
        INTR
    } cu_state_t;

    localparam logic [2:0] F3_MRET = 3'b000;

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bus: decoded instruction fields and the interrupt request in,
// datapath strobes and the retired-instruction count out.
interface otter_cu_fsm_if #(
    parameter int INSTRET_W = 64
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 intr;
    logic                 pc_rst;
    logic                 pc_we;
    logic                 rf_we;
    logic                 mem_rden1;
    logic                 mem_rden2;
    logic                 mem_we2;
    logic                 csr_we;
    logic                 int_taken;
    logic                 mret_exec;
    logic                 illegal;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  opcode, funct3, intr,
        output pc_rst, pc_we, rf_we, mem_rden1, mem_rden2, mem_we2,
               csr_we, int_taken, mret_exec, illegal, instret
    );

    modport slave (
        output opcode, funct3, intr,
        input  pc_rst, pc_we, rf_we, mem_rden1, mem_rden2, mem_we2,
               csr_we, int_taken, mret_exec, illegal, instret
    );
endinterface

// File: rtl/otter_cu_fsm_instret_ctr.sv
// Retired-instruction counter; wraps silently at 2^INSTRET_W.
module otter_instret_ctr #(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [INSTRET_W-1:0] count
);
    logic [INSTRET_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (inc)
            r_count <= r_count + INSTRET_W'(1);
    end

    assign count = r_count;
endmodule

// File: rtl/otter_cu_fsm.sv
// Otter multicycle control unit: FETCH/EXEC/WB sequencing with interrupt entry
// at instruction boundaries; strobes are decoded combinationally from state.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int INSTRET_W = 64,
    parameter bit INTR_EN   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    otter_cu_fsm_if.master bus
);
    cu_state_t            r_state;
    logic                 w_intr_req;
    logic                 w_inc;
    logic [INSTRET_W-1:0] w_count;

    assign w_intr_req = bus.intr && INTR_EN;

    // intr is only looked at when an instruction finishes (EXEC or WB exit)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            case (r_state)
                INIT:    r_state <= FETCH;
                FETCH:   r_state <= EXEC;
                EXEC: begin
                    if (bus.opcode == LOAD)
                        r_state <= WB;
                    else
                        r_state <= w_intr_req ? INTR : FETCH;
                end
                WB:      r_state <= w_intr_req ? INTR : FETCH;
                INTR:    r_state <= FETCH;
                default: r_state <= INIT;
            endcase
        end
    end

    always_comb begin
        bus.pc_rst    = 1'b0;
        bus.pc_we     = 1'b0;
        bus.rf_we     = 1'b0;
        bus.mem_rden1 = 1'b0;
        bus.mem_rden2 = 1'b0;
        bus.mem_we2   = 1'b0;
        bus.csr_we    = 1'b0;
        bus.int_taken = 1'b0;
        bus.mret_exec = 1'b0;
        bus.illegal   = 1'b0;
        if (rst) begin
            bus.pc_rst = 1'b1;
        end else begin
            case (r_state)
                INIT:  bus.pc_rst    = 1'b1;
                FETCH: bus.mem_rden1 = 1'b1;
                EXEC: begin
                    case (bus.opcode)
                        LOAD: bus.mem_rden2 = 1'b1;
                        OP, OP_IMM, LUI, AUIPC, JAL, JALR: begin
                            bus.pc_we = 1'b1;
                            bus.rf_we = 1'b1;
                        end
                        STORE: begin
                            bus.pc_we   = 1'b1;
                            bus.mem_we2 = 1'b1;
                        end
                        BRANCH: bus.pc_we = 1'b1;
                        SYSTEM: begin
                            bus.pc_we = 1'b1;
                            // CSRRW/CSRRS/CSRRC write both the CSR and rd
                            if (bus.funct3 inside {3'b001, 3'b010, 3'b011}) begin
                                bus.rf_we  = 1'b1;
                                bus.csr_we = 1'b1;
                            end else if (bus.funct3 == F3_MRET) begin
                                bus.mret_exec = 1'b1;
                            end
                        end
                        default: begin
                            bus.pc_we   = 1'b1;
                            bus.illegal = 1'b1;
                        end
                    endcase
                end
                WB: begin
                    bus.rf_we = 1'b1;
                    bus.pc_we = 1'b1;
                end
                INTR: begin
                    bus.int_taken = 1'b1;
                    bus.pc_we     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_inc = bus.pc_we && (r_state == EXEC || r_state == WB) && !rst;

    otter_instret_ctr #(
        .INSTRET_W (INSTRET_W)
    ) u_instret (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc),
        .count (w_count)
    );

    assign bus.instret = w_count;
endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: per-cycle vector table plus a wrap run,
// expectations queued at drive time and compared mid-cycle.
module tb_otter_cu_fsm;
    import otter_pkg::*;

    localparam int W = 4;

    localparam logic [9:0] PCRST = 10'b1000000000;
    localparam logic [9:0] PCWE  = 10'b0100000000;
    localparam logic [9:0] RFWE  = 10'b0010000000;
    localparam logic [9:0] RDEN1 = 10'b0001000000;
    localparam logic [9:0] RDEN2 = 10'b0000100000;
    localparam logic [9:0] WE2   = 10'b0000010000;
    localparam logic [9:0] CSRWE = 10'b0000001000;
    localparam logic [9:0] INTT  = 10'b0000000100;
    localparam logic [9:0] MRET  = 10'b0000000010;
    localparam logic [9:0] ILL   = 10'b0000000001;

    typedef struct {
        logic         rst;
        logic [6:0]   opcode;
        logic [2:0]   funct3;
        logic         intr;
        logic [9:0]   expOut;
        logic [W-1:0] expInstret;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   rowNum = 0;
    vec_t vecs[$];
    vec_t expQ[$];

    otter_cu_fsm_if #(.INSTRET_W(W)) bus();

    otter_cu_fsm #(
        .INSTRET_W (W),
        .INTR_EN   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [6:0] op, logic [2:0] f3, logic irq,
                                logic [9:0] eo, int ei);
        vec_t v;
        v.rst        = r;
        v.opcode     = op;
        v.funct3     = f3;
        v.intr       = irq;
        v.expOut     = eo;
        v.expInstret = W'(ei);
        return v;
    endfunction

    task automatic checkOutput();
        vec_t       e;
        logic [9:0] act;
        e   = expQ.pop_front();
        act = {bus.pc_rst, bus.pc_we, bus.rf_we, bus.mem_rden1, bus.mem_rden2,
               bus.mem_we2, bus.csr_we, bus.int_taken, bus.mret_exec, bus.illegal};
        checks++;
        if (act !== e.expOut) begin
            errors++;
            $display("[TB] FAIL strobes row %0d: got %b want %b", rowNum, act, e.expOut);
        end
        checks++;
        if (bus.instret !== e.expInstret) begin
            errors++;
            $display("[TB] FAIL instret row %0d: got %0d want %0d", rowNum, bus.instret, e.expInstret);
        end
        rowNum++;
    endtask

    // One clock cycle: drive just after the edge, compare on the falling edge
    task automatic applyStimulus(vec_t v);
        @(posedge clk);
        #1;
        rst        = v.rst;
        bus.opcode = v.opcode;
        bus.funct3 = v.funct3;
        bus.intr   = v.intr;
        expQ.push_back(v);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        rst        = 1'b1;
        bus.opcode = 7'b0;
        bus.funct3 = 3'b0;
        bus.intr   = 1'b0;

        vecs.push_back(mk(1, OP_IMM, 0, 0, PCRST, 0));
        vecs.push_back(mk(1, OP_IMM, 0, 0, PCRST, 0));
        vecs.push_back(mk(0, OP_IMM, 0, 0, PCRST, 0));
        vecs.push_back(mk(0, OP_IMM, 0, 0, RDEN1, 0));
        vecs.push_back(mk(0, OP_IMM, 0, 0, PCWE | RFWE, 0));
        vecs.push_back(mk(0, LOAD,   0, 0, RDEN1, 1));
        vecs.push_back(mk(0, LOAD,   0, 0, RDEN2, 1));
        vecs.push_back(mk(0, LOAD,   0, 0, PCWE | RFWE, 1));
        vecs.push_back(mk(0, STORE,  0, 0, RDEN1, 2));
        vecs.push_back(mk(0, STORE,  0, 0, PCWE | WE2, 2));
        vecs.push_back(mk(0, BRANCH, 0, 0, RDEN1, 3));
        vecs.push_back(mk(0, BRANCH, 0, 1, PCWE, 3));
        vecs.push_back(mk(0, OP,     0, 1, PCWE | INTT, 4));
        vecs.push_back(mk(0, OP,     0, 1, RDEN1, 4));
        vecs.push_back(mk(0, OP,     0, 1, PCWE | RFWE, 4));
        vecs.push_back(mk(0, OP,     0, 0, PCWE | INTT, 5));
        vecs.push_back(mk(0, SYSTEM, 3'b000, 0, RDEN1, 5));
        vecs.push_back(mk(0, SYSTEM, 3'b000, 1, PCWE | MRET, 5));
        vecs.push_back(mk(0, SYSTEM, 3'b000, 0, PCWE | INTT, 6));
        vecs.push_back(mk(0, SYSTEM, 3'b001, 0, RDEN1, 6));
        vecs.push_back(mk(0, SYSTEM, 3'b001, 0, PCWE | RFWE | CSRWE, 6));
        vecs.push_back(mk(0, 7'b1111111, 0, 0, RDEN1, 7));
        vecs.push_back(mk(0, 7'b1111111, 0, 0, PCWE | ILL, 7));
        vecs.push_back(mk(0, LUI,    0, 0, RDEN1, 8));
        vecs.push_back(mk(0, LUI,    0, 0, PCWE | RFWE, 8));
        vecs.push_back(mk(0, SYSTEM, 3'b101, 0, RDEN1, 9));
        vecs.push_back(mk(0, SYSTEM, 3'b101, 0, PCWE, 9));
        vecs.push_back(mk(0, JAL,    0, 0, RDEN1, 10));
        vecs.push_back(mk(0, JAL,    0, 0, PCWE | RFWE, 10));
        vecs.push_back(mk(0, LOAD,   0, 0, RDEN1, 11));
        vecs.push_back(mk(0, LOAD,   0, 0, RDEN2, 11));
        vecs.push_back(mk(1, LOAD,   0, 1, PCRST, 11));
        vecs.push_back(mk(0, LOAD,   0, 0, PCRST, 0));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Sixteen retirements from reset must bring the 4-bit counter back to 0
        for (int i = 0; i < 16; i++) begin
            logic [6:0] op;
            op = (i % 2 == 0) ? JALR : AUIPC;
            applyStimulus(mk(0, op, 0, 0, RDEN1, i));
            applyStimulus(mk(0, op, 0, 0, PCWE | RFWE, i));
        end
        applyStimulus(mk(0, OP_IMM, 0, 0, RDEN1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
